serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//  Bit-serial magnitude comparator: takes two WIDTH-bit operands MSB-first, one bit pair per
//  handshake, and returns a registered one-hot {a_greater, equal, b_greater} result.
//  Sequential counterpart of the 4-bit parallel comparator. Used where operands arrive from
//  shift registers or serial links. Also acts as a target for the vector-driven comparator bench.
// PARAMETERS
//  WIDTH    4   operand width in bits; must be >= 2
//  CNT_W    $clog2(WIDTH)   bit-counter width (derived; do not override)
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  1-cycle pulse: begin a new compare frame
//  bit_valid  in   1  bit_a/bit_b hold a valid bit pair
//  bit_a      in   1  operand A bit, MSB first
//  bit_b      in   1  operand B bit, MSB first
//  bit_ready  out  1  block accepts a bit pair this cycle
//  res_valid  out  1  result available
//  res_ready  in   1  consumer takes the result
//  a_greater  out  1  A > B
//  equal      out  1  A == B
//  b_greater  out  1  B > A
//  busy       out  1  high in SHIFT or DONE
// BEHAVIOUR
//  Reset: state=IDLE, bit_ready=0, res_valid=0, busy=0, a_greater=equal=b_greater=0, cnt=0.
//  Reset takes effect immediately, including mid-frame. A partial frame is discarded.
//  FSM IDLE -> SHIFT on start. On entry: cnt=0, decided=0.
//  In IDLE, bit_ready=0, so bit_valid is ignored, even when it coincides with start.
//  SHIFT: bit_ready=1. A bit pair is accepted when bit_valid & bit_ready.
//   - If decided==0 and bit_a!=bit_b: decided<=1 and gt<=bit_a. The first differing bit decides.
//   - Later bits never change a decided outcome.
//   - Gaps in bit_valid stall the frame. There is no timeout.
//   - An accept with cnt==WIDTH-1 moves to DONE and latches the one-hot result.
//     Result is equal when decided==0 after the last bit.
//   - Otherwise an accept increments cnt.
//  start while in SHIFT restarts the frame: cnt=0, decided=0, and any bit offered that cycle
//  is dropped. start while in DONE is ignored.
//  DONE: res_valid=1, bit_ready=0. On res_ready the block returns to IDLE.
//  Latency: res_valid rises the cycle after the final bit is accepted. Minimum frame is
//  1 (start) + WIDTH + 1 cycles.
//  Result outputs are exactly one-hot whenever res_valid=1. After the handshake they hold
//  their value until the next result latches.
//  busy = (state != IDLE).
// CONFIGURATION
//  SIGNED_CMP_EN defined: adds input port `signed_mode` (1 bit), sampled at start.
//   - When signed_mode=1, operands are two's complement.
//   - If the MSB pair differs, the operand whose MSB is 1 is smaller: gt<=bit_b.
//   - If the MSB pair is equal, compare the remaining bits as unsigned.
//  SIGNED_CMP_EN undefined: no signed_mode port; all compares are unsigned.
// STRUCTURE
//  Package comparator_pkg:
//   - typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_e
//   - typedef struct packed {logic a_gt, eq, b_gt;} cmp_result_t
//   - localparam cmp_result_t RES_RESET = '0
//  Sub-module serial_cmp_cell holds the sticky decided/gt flags.
//   - Inputs: clear, accept, first_bit, signed_mode, bit_a, bit_b.
//   - Outputs: decided, gt.
//  The top level owns the FSM, the counter and the result register.
// TESTING  (WIDTH=4 unless noted)
//  1. A=1010, B=0111, bit_valid held high -> res_valid 5 cycles after start; a_greater=1.
//  2. A=0101, B=0101 with bit_valid gaps of 2 cycles -> equal=1; no result before the 4th accept.
//  3. A=0011, B=1000, res_ready low 6 cycles -> b_greater=1.
//     res_valid and the result stay stable; bit_ready=0 throughout; IDLE after res_ready.
//  4. start again after 2 bits of A=1111/B=0000, then send A=0001/B=0010 -> b_greater=1.
//     The aborted bits have no effect.
//  5. rst_n low after bit 3 -> all outputs 0 at once.
//     A fresh frame A=1001/B=1000 then gives a_greater=1.
//  6. SIGNED_CMP_EN, signed_mode=1: A=1000(-8), B=0111(+7) -> b_greater=1.
//     With signed_mode=0 the same operands give a_greater=1. WIDTH=8 regression over
//     256 random pairs vs reference compare -> 0 errors.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, one-hot result, result decode.
package comparator_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} cmp_state_e;

  typedef struct packed {
    logic a_gt;
    logic eq;
    logic b_gt;
  } cmp_result_t;

  localparam cmp_result_t RES_RESET = '0;

  function automatic cmp_result_t resolve_result(input logic decided, input logic gt);
    cmp_result_t r;
    r.a_gt = decided & gt;
    r.eq   = ~decided;
    r.b_gt = decided & ~gt;
    return r;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cell.sv
// Sticky decision cell: records whether and how the first differing bit pair decided the compare.
module serial_cmp_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic accept,
  input  logic first_bit,
  input  logic signed_mode,
  input  logic bit_a,
  input  logic bit_b,
  output logic decided,
  output logic gt
);

  logic decided_q, decided_d;
  logic gt_q, gt_d;
  logic gt_new;

  always_comb begin
    // A differing sign bit in two's complement favours the operand whose MSB is 0.
    gt_new    = (signed_mode & first_bit) ? bit_b : bit_a;
    decided_d = decided_q;
    gt_d      = gt_q;
    if (clear) begin
      decided_d = 1'b0;
      gt_d      = 1'b0;
    end else if (accept && !decided_q && (bit_a != bit_b)) begin
      decided_d = 1'b1;
      gt_d      = gt_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      decided_q <= decided_d;
      gt_q      <= gt_d;
    end
  end

  // Next-state view so the final bit pair is included when the top latches the result.
  assign decided = decided_d;
  assign gt      = gt_d;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready bit input and result handshake.
// Optional two's complement mode when SIGNED_CMP_EN is defined (adds signed_mode port).
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SIGNED_CMP_EN
  input  logic signed_mode,
`endif
  input  logic start,
  input  logic bit_valid,
  input  logic bit_a,
  input  logic bit_b,
  output logic bit_ready,
  output logic res_valid,
  input  logic res_ready,
  output logic a_greater,
  output logic equal,
  output logic b_greater,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmp_result_t      res_q, res_d;
  logic             signed_q;
  logic             clear, accept;
  logic             decided, gt;

`ifdef SIGNED_CMP_EN
  logic signed_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) signed_q <= 1'b0;
    else        signed_q <= signed_d;
  end
`else
  assign signed_q = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    clear     = 1'b0;
    accept    = 1'b0;
    bit_ready = 1'b0;
    res_valid = 1'b0;
`ifdef SIGNED_CMP_EN
    signed_d  = signed_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          clear   = 1'b1;
`ifdef SIGNED_CMP_EN
          signed_d = signed_mode;
`endif
        end
      end
      SHIFT: begin
        bit_ready = 1'b1;
        // A restart wins over any bit pair offered in the same cycle.
        if (start) begin
          cnt_d = '0;
          clear = 1'b1;
`ifdef SIGNED_CMP_EN
          signed_d = signed_mode;
`endif
        end else if (bit_valid) begin
          accept = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            res_d   = resolve_result(decided, gt);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= RES_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  serial_cmp_cell u_cell (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .accept     (accept),
    .first_bit  (cnt_q == '0),
    .signed_mode(signed_q),
    .bit_a      (bit_a),
    .bit_b      (bit_b),
    .decided    (decided),
    .gt         (gt)
  );

  assign busy      = (state_q != IDLE);
  assign a_greater = res_q.a_gt;
  assign equal     = res_q.eq;
  assign b_greater = res_q.b_gt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=4); signed cases when SIGNED_CMP_EN is defined.
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 4;
  localparam logic [2:0] A_GT = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] B_GT = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, bit_valid = 1'b0, bit_a = 1'b0, bit_b = 1'b0, res_ready = 1'b0;
  logic bit_ready, res_valid, a_greater, equal, b_greater, busy;
`ifdef SIGNED_CMP_EN
  logic signed_mode = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SIGNED_CMP_EN
    .signed_mode(signed_mode),
`endif
    .start    (start),
    .bit_valid(bit_valid),
    .bit_a    (bit_a),
    .bit_b    (bit_b),
    .bit_ready(bit_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .a_greater(a_greater),
    .equal    (equal),
    .b_greater(b_greater),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected result per result handshake.
  initial begin
    logic [2:0] exp_r;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 8'd1, 8'd0);
        end else begin
          exp_r = sb.pop_front();
          chk("sb_result", {5'd0, a_greater, equal, b_greater}, {5'd0, exp_r});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic va, input logic a, input logic b);
    start = 1'b1; bit_valid = va; bit_a = a; bit_b = b;
    tick();
    start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int n, input int gap);
    for (int i = WIDTH - 1; i >= WIDTH - n; i--) begin
      chk("no_early_result", {7'd0, res_valid}, 8'd0);
      chk("bit_ready_shift", {7'd0, bit_ready}, 8'd1);
      bit_valid = 1'b1; bit_a = a[i]; bit_b = b[i];
      tick();
      bit_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic finish_frame(input logic [2:0] exp_r, input int hold);
    sb.push_back(exp_r);
    chk("res_valid_latency", {7'd0, res_valid}, 8'd1);
    repeat (hold) begin
      chk("hold_res_valid", {7'd0, res_valid}, 8'd1);
      chk("hold_result", {5'd0, a_greater, equal, b_greater}, {5'd0, exp_r});
      chk("hold_bit_ready", {7'd0, bit_ready}, 8'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_handshake", {7'd0, busy}, 8'd0);
    chk("result_held", {5'd0, a_greater, equal, b_greater}, {5'd0, exp_r});
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] exp_r, input int gap, input int hold);
    do_start(1'b0, 1'b0, 1'b0);
    send_bits(a, b, WIDTH, gap);
    finish_frame(exp_r, hold);
  endtask

  initial begin
    #2;
    chk("reset_outputs", {2'd0, bit_ready, res_valid, a_greater, equal, b_greater, busy}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: bit_valid high through start (ignored in IDLE) and all bits.
    do_start(1'b1, 1'b0, 1'b1);
    send_bits(4'b1010, 4'b0111, WIDTH, 0);
    finish_frame(A_GT, 0);

    // 2: gaps of two cycles between bits.
    run_frame(4'b0101, 4'b0101, EQ, 2, 0);

    // 3: consumer stalls for six cycles.
    run_frame(4'b0011, 4'b1000, B_GT, 0, 6);

    // 4: restart mid-frame with a bit pair offered in the restart cycle.
    do_start(1'b0, 1'b0, 1'b0);
    send_bits(4'b1111, 4'b0000, 2, 0);
    start = 1'b1; bit_valid = 1'b1; bit_a = 1'b1; bit_b = 1'b0;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("busy_after_restart", {7'd0, busy}, 8'd1);
    send_bits(4'b0001, 4'b0010, WIDTH, 0);
    finish_frame(B_GT, 0);

    // 5: asynchronous reset mid-frame, then a fresh frame.
    do_start(1'b0, 1'b0, 1'b0);
    send_bits(4'b1111, 4'b0000, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {2'd0, bit_ready, res_valid, a_greater, equal, b_greater, busy}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(4'b1001, 4'b1000, A_GT, 0, 0);

    // Boundaries: decided only by LSB, all-equal extremes, MSB decides.
    run_frame(4'b0001, 4'b0000, A_GT, 0, 0);
    run_frame(4'b0000, 4'b0001, B_GT, 1, 0);
    run_frame(4'b1111, 4'b1111, EQ,   0, 1);
    run_frame(4'b0000, 4'b0000, EQ,   0, 0);
    run_frame(4'b1000, 4'b0111, A_GT, 0, 0);

    // Start while DONE is ignored.
    do_start(1'b0, 1'b0, 1'b0);
    send_bits(4'b0110, 4'b1001, WIDTH, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", {7'd0, res_valid}, 8'd1);
    finish_frame(B_GT, 0);

`ifdef SIGNED_CMP_EN
    signed_mode = 1'b1;
    run_frame(4'b1000, 4'b0111, B_GT, 0, 0);
    run_frame(4'b1111, 4'b1110, A_GT, 0, 0);
    run_frame(4'b0001, 4'b1111, A_GT, 0, 0);
    signed_mode = 1'b0;
    run_frame(4'b1000, 4'b0111, A_GT, 0, 0);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
